// File: rtl/adrv9009_tone_gen_pkg.sv
// Shared types, register map and step-amplitude lookup for the multi-tone stimulus source.
// Pure declarations; no state.
package adrv9009_tone_gen_pkg;

  typedef enum logic [1:0] {
    SHP_OFF   = 2'b00,
    SHP_SINE8 = 2'b01,
    SHP_TRI4  = 2'b10,
    SHP_SQR   = 2'b11
  } shape_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [7:0] ADDR_TONE_BASE = 8'h00;
  localparam logic [7:0] ADDR_SEG_BASE  = 8'h40;
  localparam logic [7:0] ADDR_LOOP      = 8'h80;

  function automatic logic [2:0] last_step(input logic [1:0] shape);
    case (shape)
      SHP_SINE8: return 3'd7;
      SHP_TRI4:  return 3'd3;
      SHP_SQR:   return 3'd1;
      default:   return 3'd0;
    endcase
  endfunction

  // All arithmetic folds to constants because data_w is always a parameter.
  function automatic longint step_amp(input logic [1:0] shape, input logic [2:0] step,
                                      input int data_w);
    longint fs, nf, k, v;
    fs = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    nf = -fs - 64'sd1;
    k  = (fs * 64'sd70710678 + 64'sd50000000) / 64'sd100000000;
    v  = 64'sd0;
    case (shape)
      SHP_SINE8: begin
        case (step)
          3'd1, 3'd3: v = k;
          3'd2:       v = fs;
          3'd5, 3'd7: v = -k;
          3'd6:       v = nf;
          default:    v = 64'sd0;
        endcase
      end
      SHP_TRI4: begin
        case (step[1:0])
          2'd1:    v = fs;
          2'd3:    v = nf;
          default: v = 64'sd0;
        endcase
      end
      SHP_SQR: v = step[0] ? fs : nf;
      default: v = 64'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/adrv9009_tone_osc.sv
// One stepped-waveform oscillator; amp is combinational from the current (or restarted) phase.
// Phase advances once per emitted sample, each step held period+1 samples; no backpressure.
module adrv9009_tone_osc #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 10
) (
  input  logic                     clk_m,
  input  logic                     reset_n,
  input  logic [1:0]               shape,
  input  logic [CNT_W-1:0]         period,
  input  logic                     restart,
  input  logic                     adv,
  output logic signed [DATA_W-1:0] amp
);
  import adrv9009_tone_gen_pkg::*;

  logic [2:0]       step_q, step_d, eff_step;
  logic [CNT_W-1:0] cnt_q, cnt_d, eff_cnt;

  // restart lets the sample taken on the start edge already use step 0.
  always_comb begin
    eff_step = restart ? 3'd0 : step_q;
    eff_cnt  = restart ? '0 : cnt_q;
    amp      = DATA_W'(step_amp(shape, eff_step, DATA_W));
    step_d   = eff_step;
    cnt_d    = eff_cnt;
    if (adv) begin
      if (eff_cnt == period) begin
        cnt_d  = '0;
        step_d = (eff_step >= last_step(shape)) ? 3'd0 : eff_step + 3'd1;
      end else begin
        cnt_d  = eff_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_m or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= '0;
      cnt_q  <= '0;
    end else begin
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/adrv9009_tone_gen.sv
// Multi-tone segment-sequenced stimulus source; out is registered, first sample the cycle after start.
// No backpressure; optional ADRV9009_TONE_GEN_DITHER_EN adds an LFSR LSB dither before saturation.
module adrv9009_tone_gen #(
  parameter int DATA_W    = 16,
  parameter int NUM_TONES = 4,
  parameter int CNT_W     = 10,
  parameter int NUM_SEG   = 8
) (
  input  logic                     clk_m,
  input  logic                     reset_n,
  input  logic                     cfg_wr_en,
  input  logic [7:0]               cfg_addr,
  input  logic [31:0]              cfg_wdata,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [3:0]               seg_idx,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid,
  output logic                     sat_flag,
  output logic                     done
);
  import adrv9009_tone_gen_pkg::*;

  localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic signed [DATA_W+2:0] SUM_MAX = {4'b0000, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W+2:0] SUM_MIN = {4'b1111, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] FS_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] NF_V = {1'b1, {(DATA_W-1){1'b0}}};

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           tone_per_q [NUM_TONES];
  logic [CNT_W-1:0]           tone_per_d [NUM_TONES];
  logic [1:0]                 tone_shp_q [NUM_TONES];
  logic [1:0]                 tone_shp_d [NUM_TONES];
  logic [15:0]                seg_len_q  [NUM_SEG];
  logic [15:0]                seg_len_d  [NUM_SEG];
  logic [NUM_TONES-1:0]       seg_mask_q [NUM_SEG];
  logic [NUM_TONES-1:0]       seg_mask_d [NUM_SEG];
  logic                       loop_q, loop_d;
  logic [SEG_W-1:0]           seg_q, seg_d;
  logic [15:0]                rem_q, rem_d;
  logic signed [DATA_W-1:0]   out_q, out_d;
  logic                       out_valid_q, sat_q, sat_d, done_q, done_d;
  logic                       emit, restart, clip, first_vld, nxt_vld;
  logic [SEG_W-1:0]           first_idx, nxt_idx;
  logic [NUM_TONES-1:0]       mask_sel;
  logic signed [DATA_W-1:0]   tone_amp [NUM_TONES];
  logic signed [DATA_W+2:0]   sum;
  logic signed [DATA_W-1:0]   sat_val;
  logic                       unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  // Config is frozen while running so a sequence always sees one consistent setup.
  always_comb begin
    tone_per_d = tone_per_q;
    tone_shp_d = tone_shp_q;
    seg_len_d  = seg_len_q;
    seg_mask_d = seg_mask_q;
    loop_d     = loop_q;
    if (cfg_wr_en && state_q != ST_RUN) begin
      for (int t = 0; t < NUM_TONES; t++) begin
        if (cfg_addr == ADDR_TONE_BASE + 8'(t)) begin
          tone_per_d[t] = cfg_wdata[CNT_W-1:0];
          tone_shp_d[t] = cfg_wdata[17:16];
        end
      end
      for (int s = 0; s < NUM_SEG; s++) begin
        if (cfg_addr == ADDR_SEG_BASE + 8'(s)) begin
          seg_len_d[s]  = cfg_wdata[15:0];
          seg_mask_d[s] = cfg_wdata[16 +: NUM_TONES];
        end
      end
      if (cfg_addr == ADDR_LOOP) loop_d = cfg_wdata[0];
    end
  end

  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    nxt_vld   = 1'b0;
    nxt_idx   = '0;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      if (seg_len_q[i] != 16'd0) begin
        first_vld = 1'b1;
        first_idx = SEG_W'(i);
      end
      if (SEG_W'(i) > seg_q && seg_len_q[i] != 16'd0) begin
        nxt_vld = 1'b1;
        nxt_idx = SEG_W'(i);
      end
    end
    if (!nxt_vld && loop_q) begin
      nxt_vld = first_vld;
      nxt_idx = first_idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    emit     = 1'b0;
    restart  = 1'b0;
    mask_sel = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          restart = 1'b1;
          if (first_vld) begin
            state_d  = ST_RUN;
            seg_d    = first_idx;
            rem_d    = seg_len_q[first_idx] - 16'd1;
            mask_sel = seg_mask_q[first_idx];
            emit     = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (rem_q != 16'd0) begin
          rem_d    = rem_q - 16'd1;
          mask_sel = seg_mask_q[seg_q];
          emit     = 1'b1;
        end else if (nxt_vld) begin
          seg_d    = nxt_idx;
          rem_d    = seg_len_q[nxt_idx] - 16'd1;
          mask_sel = seg_mask_q[nxt_idx];
          emit     = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar t = 0; t < NUM_TONES; t++) begin : g_tone
    adrv9009_tone_osc #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_osc (
      .clk_m   (clk_m),
      .reset_n (reset_n),
      .shape   (tone_shp_q[t]),
      .period  (tone_per_q[t]),
      .restart (restart),
      .adv     (emit),
      .amp     (tone_amp[t])
    );
  end

`ifdef ADRV9009_TONE_GEN_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d, lfsr_eff;

  always_comb begin
    lfsr_eff = restart ? LFSR_SEED : lfsr_q;
    lfsr_d   = lfsr_eff;
    if (emit) lfsr_d = {lfsr_eff[14:0], lfsr_eff[15] ^ lfsr_eff[13] ^ lfsr_eff[12] ^ lfsr_eff[10]};
  end

  always_ff @(posedge clk_m or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
    sum = '0;
    for (int t = 0; t < NUM_TONES; t++) begin
      if (mask_sel[t]) sum = sum + (DATA_W+3)'(tone_amp[t]);
    end
`ifdef ADRV9009_TONE_GEN_DITHER_EN
    sum = sum + {{(DATA_W+2){1'b0}}, lfsr_eff[0]};
`endif
    clip    = (sum > SUM_MAX) || (sum < SUM_MIN);
    sat_val = clip ? (sum[DATA_W+2] ? NF_V : FS_V) : sum[DATA_W-1:0];
    out_d   = emit ? sat_val : '0;
    sat_d   = (restart ? 1'b0 : sat_q) | (emit & clip);
  end

  always_ff @(posedge clk_m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < NUM_TONES; i++) begin
        tone_per_q[i] <= '0;
        tone_shp_q[i] <= '0;
      end
      for (int i = 0; i < NUM_SEG; i++) begin
        seg_len_q[i]  <= '0;
        seg_mask_q[i] <= '0;
      end
      loop_q      <= 1'b0;
      seg_q       <= '0;
      rem_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tone_per_q  <= tone_per_d;
      tone_shp_q  <= tone_shp_d;
      seg_len_q   <= seg_len_d;
      seg_mask_q  <= seg_mask_d;
      loop_q      <= loop_d;
      seg_q       <= seg_d;
      rem_q       <= rem_d;
      out_q       <= out_d;
      out_valid_q <= emit;
      sat_q       <= sat_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign seg_idx   = 4'(seg_q);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;
  assign done      = done_q;

endmodule
